// File: rtl/fifo_pkg.sv
// Shared pointer helpers for the dual-clock FIFO controllers.
// Gray/binary conversions work on 32-bit vectors; callers size-cast to their pointer width.
package fifo_pkg;

   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic logic [31:0] bin2gray(input logic [31:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   // Each binary bit is the XOR of all Gray bits at or above it.
   function automatic logic [31:0] gray2bin(input logic [31:0] gray);
      logic [31:0] bin;
      bin[31] = gray[31];
      for (int i = 30; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer bus crossing clock domains.
// Only one bit changes per pointer step, so a per-bit flop chain is safe.
module gray_sync #(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage [SYNC_STAGES];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            stage[i] <= '0;
         end
      end else begin
         stage[0] <= din;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign dout = stage[SYNC_STAGES-1];

endmodule

// File: rtl/wr_ptr_ctrl.sv
// Write-side pointer and status controller for the UART-path dual-clock FIFO.
// Optional sticky overflow flag (ovf_o / ovf_clr_i) is built when WR_PTR_CTRL_OVF_EN is defined.
module wr_ptr_ctrl
   import fifo_pkg::*;
#(
   parameter int FIFO_WIDTH   = 8,
   parameter int FIFO_DEPTH   = 8,
   parameter int ADDR         = $clog2(FIFO_DEPTH),
   parameter int SYNC_STAGES  = 2,
   parameter int AFULL_THRESH = FIFO_DEPTH - 2,
   parameter int DLY          = 1
) (
   input  logic                  wr_clk_i,
   input  logic                  rst_i,
`ifdef WR_PTR_CTRL_OVF_EN
   input  logic                  ovf_clr_i,
   output logic                  ovf_o,
`endif
   input  logic                  wr_en_i,
   input  logic [FIFO_WIDTH-1:0] wr_data_i,
   input  logic [ADDR:0]         rd_gray_i,
   output logic                  mem_we_o,
   output logic [ADDR-1:0]       mem_addr_o,
   output logic [FIFO_WIDTH-1:0] mem_data_o,
   output logic [ADDR:0]         wr_gray_o,
   output logic                  full_o,
   output logic                  afull_o,
   output logic [ADDR:0]         wr_level_o
);

   localparam int PW = ptr_width(FIFO_DEPTH);
   localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

   // DLY is kept only for parameter compatibility with the older controller and is range-checked here.
   generate
      if (PW != ADDR + 1 || FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
          SYNC_STAGES < 2 || AFULL_THRESH < 1 || AFULL_THRESH > FIFO_DEPTH - 1 || DLY < 0) begin : g_bad_param
         $error("wr_ptr_ctrl: illegal parameter combination");
      end
   endgenerate

   logic          accept;
   logic [PW-1:0] wr_bin;
   logic [PW-1:0] wr_bin_next;
   logic [PW-1:0] wr_gray_next;
   logic [PW-1:0] rd_gray_s;
   logic [PW-1:0] rd_bin_s;
   logic [PW-1:0] full_pattern;
   logic [PW-1:0] level_next;

   gray_sync #(
      .WIDTH       (PW),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_rd_sync (
      .clock (wr_clk_i),
      .reset (rst_i),
      .din   (rd_gray_i),
      .dout  (rd_gray_s)
   );

   assign accept     = wr_en_i & ~full_o & ~rst_i;
   assign mem_we_o   = accept;
   assign mem_addr_o = wr_bin[ADDR-1:0];
   assign mem_data_o = wr_data_i;

   assign wr_bin_next  = wr_bin + PW'(accept);
   assign wr_gray_next = PW'(bin2gray(32'(wr_bin_next)));
   assign rd_bin_s     = PW'(gray2bin(32'(rd_gray_s)));

   // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted, rest equal.
   assign full_pattern = {~rd_gray_s[PW-1:PW-2], rd_gray_s[PW-3:0]};
   assign level_next   = wr_bin_next - rd_bin_s;

   // Status is derived from next-state values so it lines up with the pointer it describes.
   always_ff @(posedge wr_clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_bin     <= '0;
         wr_gray_o  <= '0;
         full_o     <= 1'b0;
         afull_o    <= 1'b0;
         wr_level_o <= '0;
      end else begin
         wr_bin     <= wr_bin_next;
         wr_gray_o  <= wr_gray_next;
         full_o     <= (wr_gray_next == full_pattern);
         afull_o    <= (level_next >= AFULL_LVL);
         wr_level_o <= level_next;
      end
   end

`ifdef WR_PTR_CTRL_OVF_EN
   // A lost write wins over a clear arriving in the same cycle.
   always_ff @(posedge wr_clk_i or posedge rst_i) begin
      if (rst_i) begin
         ovf_o <= 1'b0;
      end else if (wr_en_i & full_o) begin
         ovf_o <= 1'b1;
      end else if (ovf_clr_i) begin
         ovf_o <= 1'b0;
      end
   end
`endif

endmodule
